// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of mem_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_arbiter_if #(
    parameter int unsigned n = 32
);
    logic         req0;
    logic [n-1:0] addr0;
    logic         ack0;
    logic         err0;
    logic [n-1:0] rdata0;

    logic         req1;
    logic         we1;
    logic [n-1:0] addr1;
    logic [n-1:0] wdata1;
    logic         ack1;
    logic         err1;
    logic [n-1:0] rdata1;

    logic [n-1:0] mem_addr;
    logic         mem_we;
    logic [n-1:0] mem_wdata;
    logic [n-1:0] mem_rdata;

    modport slave (
        input  req0, addr0, req1, we1, addr1, wdata1, mem_rdata,
        output ack0, err0, rdata0, ack1, err1, rdata1, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0, addr0, req1, we1, addr1, wdata1, mem_rdata,
        input  ack0, err0, rdata0, ack1, err1, rdata1, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing a single-port word memory.
// One transaction per three cycles: grant (IDLE), ACCESS, ACK; every output registered.
module mem_arbiter #(
    parameter int unsigned n         = 32,
    parameter int unsigned ADDR_BITS = 8
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

    state_e       state_q, state_d;
    logic         rr_last_q, rr_last_d;
    logic         port_q, port_d;
    logic         illegal_q, illegal_d;
    logic [n-1:0] mem_addr_q, mem_addr_d;
    logic [n-1:0] mem_wdata_q, mem_wdata_d;
    logic         mem_we_q, mem_we_d;
    logic         ack0_q, ack0_d, err0_q, err0_d;
    logic         ack1_q, ack1_d, err1_q, err1_d;
    logic [n-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic         grant_valid;
    logic         grant_port;
    logic         grant_we;
    logic         grant_illegal;
    logic [n-1:0] grant_addr;

    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        // On contention the port that did not win last time goes first
        if (bus.req0 && bus.req1) begin
            grant_port = ~rr_last_q;
        end else begin
            grant_port = bus.req1;
        end
        grant_addr    = grant_port ? bus.addr1 : bus.addr0;
        grant_we      = grant_port & bus.we1;
        grant_illegal = (grant_addr[1:0] != 2'b00) || ((grant_addr >> ADDR_BITS) != '0);
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        port_d      = port_q;
        illegal_d   = illegal_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        ack0_d      = 1'b0;
        err0_d      = 1'b0;
        rdata0_d    = '0;
        ack1_d      = 1'b0;
        err1_d      = 1'b0;
        rdata1_d    = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    port_d     = grant_port;
                    rr_last_d  = grant_port;
                    illegal_d  = grant_illegal;
                    mem_addr_d = grant_addr;
                    // Port 0 never writes, so leave the data bus untouched for it
                    if (grant_port) begin
                        mem_wdata_d = bus.wdata1;
                    end
                    mem_we_d = grant_we & ~grant_illegal;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                state_d = StAck;
                if (port_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = illegal_q;
                    rdata1_d = illegal_q ? '0 : bus.mem_rdata;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = illegal_q;
                    rdata0_d = illegal_q ? '0 : bus.mem_rdata;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_last_q   <= 1'b1;
            port_q      <= 1'b0;
            illegal_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            ack0_q      <= 1'b0;
            err0_q      <= 1'b0;
            rdata0_q    <= '0;
            ack1_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            port_q      <= port_d;
            illegal_q   <= illegal_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            ack0_q      <= ack0_d;
            err0_q      <= err0_d;
            rdata0_q    <= rdata0_d;
            ack1_q      <= ack1_d;
            err1_q      <= err1_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.ack0      = ack0_q;
    assign bus.err0      = err0_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err1      = err1_q;
    assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array model of the 256-byte memory
// (combinational read, falling-edge write).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    mem_arbiter_if #(.n(32)) bus ();

    mem_arbiter #(.n(32), .ADDR_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    wire [7:0] ma = bus.mem_addr[7:0];
    assign bus.mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (bus.mem_we) begin
            mem[ma]        <= bus.mem_wdata[7:0];
            mem[ma + 8'd1] <= bus.mem_wdata[15:8];
            mem[ma + 8'd2] <= bus.mem_wdata[23:16];
            mem[ma + 8'd3] <= bus.mem_wdata[31:24];
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic any_output();
        return |{bus.ack0, bus.err0, bus.rdata0, bus.ack1, bus.err1, bus.rdata1,
                 bus.mem_addr, bus.mem_we, bus.mem_wdata};
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int   cyc;
        logic got;
        @(negedge clk);
        if (v.port) begin
            bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
        end else begin
            bus.req0 = 1'b1; bus.addr0 = v.addr;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(v.we && !v.err));
                check({tag, "_mem_addr"}, bus.mem_addr, v.addr);
            end
            got = v.port ? bus.ack1 : bus.ack0;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd2);
        check({tag, "_err"}, 32'(v.port ? bus.err1 : bus.err0), 32'(v.err));
        check({tag, "_rdata"}, v.port ? bus.rdata1 : bus.rdata0, v.rdata);
        check({tag, "_other_ack"}, 32'(v.port ? bus.ack0 : bus.ack1), 32'd0);
        check({tag, "_we_in_ack"}, 32'(bus.mem_we), 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ack_clear"}, 32'(bus.ack0 | bus.ack1 | bus.err0 | bus.err1), 32'd0);
        check({tag, "_rdata_clear"}, bus.rdata0 | bus.rdata1, 32'd0);
    endtask

    initial begin
        int   cyc;
        int   last_cyc;
        int   n_acks;
        logic p;
        vec_t v;

        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 32'h13121110};
        vecs[1] = '{1'b1, 1'b1, 32'h20,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 32'h22,  32'h11223344, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h100, 32'h55667788, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h21,  32'h0,        1'b1, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'hFC,  32'h0,        1'b0, 32'hFFFEFDFC};
        vecs[7] = '{1'b1, 1'b0, 32'h24,  32'h0,        1'b0, 32'h27262524};

        rst_n = 1'b0;
        preload = 1'b1;
        bus.req0 = 1'b0; bus.addr0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(any_output()), 32'd0);
        preload = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        check("bytes_20_23", mem_word(32'h20), 32'hDEADBEEF);
        check("word_00_untouched", mem_word(32'h00), 32'h03020100);

        // Both ports request back to back; last grant was port 1 so port 0 leads
        @(negedge clk);
        bus.req0 = 1'b1; bus.addr0 = 32'h30;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h34;
        n_acks = 0;
        cyc = 0;
        last_cyc = 0;
        while (n_acks < 6 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ack0 || bus.ack1) begin
                p = bus.ack1;
                check("rr_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
                check($sformatf("rr%0d_port", n_acks), 32'(p), 32'(n_acks % 2));
                check($sformatf("rr%0d_rdata", n_acks), p ? bus.rdata1 : bus.rdata0,
                      p ? 32'h37363534 : 32'h33323130);
                if (n_acks > 0) check($sformatf("rr%0d_gap", n_acks), 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                n_acks++;
            end
        end
        check("rr_count", 32'(n_acks), 32'd6);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk);

        // Reset lands inside the ACCESS cycle of a write, ahead of the falling edge
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h40; bus.wdata1 = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("rst_we_before", 32'(bus.mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_we_async", 32'(bus.mem_we), 32'd0);
        check("rst_outputs", 32'(any_output()), 32'd0);
        @(posedge clk); #1;
        check("rst_no_ack", 32'(bus.ack1 | bus.ack0), 32'd0);
        bus.req1 = 1'b0;
        @(negedge clk);
        check("rst_word_40", mem_word(32'h40), 32'h43424140);
        rst_n = 1'b1;

        v = '{1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
        run_txn(v, "retry");
        check("retry_word_40", mem_word(32'h40), 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port, byte-addressed word memory (256 bytes, 32-bit little-endian words; combinational read, write on falling clock edge when WE=1). Port 0 is the read-only instruction-fetch requester, port 1 is the load/store requester. The block serializes their requests with round-robin fairness, drives the memory's Address/WE/data inputs from registers, captures the read word and returns it with a one-cycle acknowledge. It also rejects misaligned or out-of-range accesses before they reach the memory.

## Interface
- n, 32, data and address width; matches the memory's `n`
- ADDR_BITS, 8, byte-address bits actually implemented by the memory (depth = 2^ADDR_BITS bytes)
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  port 0 read request; held high until ack0
- addr0  input  n  port 0 byte address
- ack0  output  1  port 0 completion pulse, one cycle
- err0  output  1  port 0 error flag, valid with ack0
- rdata0  output  n  port 0 read word, valid with ack0
- req1  input  1  port 1 request; held high until ack1
- we1  input  1  port 1 write (1) / read (0)
- addr1  input  n  port 1 byte address
- wdata1  input  n  port 1 write word
- ack1, err1, rdata1  output  1/1/n  as for port 0
- mem_addr  output  n  to memory Address
- mem_we  output  1  to memory WE
- mem_wdata  output  n  to memory data
- mem_rdata  input  n  from memory dataout

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-low. All outputs are registered. Reset values: every output is 0. State resets to IDLE and rr_last resets to 1.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one reqX=1: grant X.
  - Both requesting: grant the port != rr_last.
  - On a grant: latch the port id, load mem_addr/mem_wdata from that port, set rr_last=granted port, go to ACCESS.
- ACCESS:
  - mem_we = granted we (port 0 is always 0), gated off when the access is illegal.
  - At the end of the cycle: capture mem_rdata into the granted port's rdata, pulse ackX, set errX if illegal, go to ACK.
- ACK:
  - ackX=1 for exactly this cycle; mem_we=0; go to IDLE.
  - ack/err/rdata outputs clear to 0 on the next cycle. rdata is not held.
- Illegal access: addr[1:0]!=0, or addr[n-1:ADDR_BITS]!=0.
  - The memory sees no write (mem_we stays 0).
  - rdataX=0, errX=1.
  - The FSM path is unchanged (same latency).
- Write response: rdata1 on a write ack equals the word read back after the falling-edge write, i.e. wdata1.
- Requesters must keep req/addr/we/wdata stable from assertion until ack. Requesters may deassert only on or after ack; changing fields mid-request is unsupported.
- The losing requester waits; no request is dropped. Maximum wait is one transaction (3 cycles) under round-robin.

## Timing
- A request sampled high at rising edge E0 with state IDLE:
  - Grant at E0.
  - ACCESS cycle is E0–E1: mem_* are stable across the falling edge, so the write lands mid-cycle.
  - ackX high in E1–E2; FSM back in IDLE at E2.
- Throughput is one transaction per 3 cycles. A request held (or new) at E2 is granted at E3.
- mem_we is high only in ACCESS cycles for legal writes; it is never high in IDLE or ACK.
- mem_addr and mem_wdata hold their last values outside ACCESS (no glitch to 0) to limit read toggling. Only mem_we gates side effects.
- Reset asserted during ACCESS:
  - mem_we drops immediately (asynchronously). If this happens before the falling edge, no write occurs.
  - No ack is issued; state returns to IDLE.
  - The requester must re-issue after reset.
- Simultaneous req0 and req1 rising in the same cycle after reset: port 0 is served first (rr_last=1), then port 1. Completion order is ack0 at cycle 2 and ack1 at cycle 5 relative to the first grant edge.

## Test plan
- Preload the memory with bytes 00..FF. Port 0 reads addr 0x10 → ack0 one cycle after the ACCESS cycle, rdata0=0x13121110, err0=0.
- Port 1 writes 0xDEADBEEF to 0x20, then port 1 reads 0x20 → both acks with err1=0; rdata1=0xDEADBEEF on both; bytes 0x20..0x23 = EF,BE,AD,DE.
- Both ports request continuously for 6 transactions → grants alternate 0,1,0,1,0,1; acks are exactly 3 cycles apart; no starvation.
- Port 1 writes to 0x22 (misaligned) and to 0x100 (out of range) → ack1 with err1=1, rdata1=0, mem_we never 1, memory contents unchanged.
- Assert rst_n=0 in the ACCESS cycle of a write to 0x40 before the falling edge → mem_we=0 immediately, no ack, word at 0x40 unchanged, all outputs 0. After release, a repeated request completes normally.
